sample_discriminator_config_sequencer: RTL and testbench

- PS-clock-domain controller that holds shadow copies of every sample discriminator setting: thresholds, delays, trigger sources and bypass mask.
- Software writes individual fields through a simple write stream, then issues a commit.
- On commit, the block drives the discriminator's four Axis_If config ports in a fixed order. Only changed groups are sent, each with a ready timeout.
- The block reports busy/done/error to the register interface.

---
 rtl/sample_discriminator_pkg.sv | 39 +++
 rtl/sample_discriminator_config_sequencer_sender.sv | 38 +++
 rtl/sample_discriminator_config_sequencer.sv | 143 ++++++++++++++
 tb/tb_sample_discriminator_config_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_discriminator_pkg.sv
// sample_discriminator_pkg: shared widths, field/group encodings and config word packing
package sample_discriminator_pkg;
  localparam int CHANNELS = 3;
  localparam int TX_CHANNELS = 2;
  localparam int SAMPLE_WIDTH = 16;
  localparam int MAX_DELAY_CYCLES = 64;
  localparam int TIMER_BITS = $clog2(MAX_DELAY_CYCLES);
  localparam int SOURCE_BITS = $clog2(CHANNELS + TX_CHANNELS);
  localparam int CHANNEL_BITS = $clog2(CHANNELS);
  localparam int THR_WIDTH = 2 * CHANNELS * SAMPLE_WIDTH;
  localparam int DLY_WIDTH = 3 * CHANNELS * TIMER_BITS;
  localparam int SRC_WIDTH = CHANNELS * SOURCE_BITS;
  localparam int BYP_WIDTH = CHANNELS;
  typedef enum logic [2:0] {
    LOW_THR, HIGH_THR, START_DLY, STOP_DLY, DIGITAL_DLY, TRIG_SRC, BYPASS, COMMIT
  } field_t;
  typedef enum logic [1:0] {GROUP_THR, GROUP_DLY, GROUP_SRC, GROUP_BYP} group_t;
  typedef logic [CHANNELS-1:0][SAMPLE_WIDTH-1:0] sample_array_t;
  typedef logic [CHANNELS-1:0][TIMER_BITS-1:0] timer_array_t;
  typedef logic [CHANNELS-1:0][SOURCE_BITS-1:0] source_array_t;
  function automatic logic [THR_WIDTH-1:0] pack_thresholds(input sample_array_t low, input sample_array_t high);
    logic [THR_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < CHANNELS; i++) w[i*2*SAMPLE_WIDTH +: 2*SAMPLE_WIDTH] = {high[i], low[i]};
    return w;
  endfunction
  function automatic logic [DLY_WIDTH-1:0] pack_delays(input timer_array_t start, input timer_array_t stop,
                                                      input timer_array_t digital);
    logic [DLY_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < CHANNELS; i++) w[i*3*TIMER_BITS +: 3*TIMER_BITS] = {digital[i], stop[i], start[i]};
    return w;
  endfunction
  function automatic group_t field_group(input field_t f);
    return (f == LOW_THR || f == HIGH_THR) ? GROUP_THR :
           (f == TRIG_SRC) ? GROUP_SRC :
           (f == BYPASS) ? GROUP_BYP : GROUP_DLY;
  endfunction
endpackage

// File: rtl/sample_discriminator_config_sequencer_sender.sv
// axis_single_word_sender: registered single-beat stream master with a ready timeout
// ports: ps_clk/ps_resetn clock and async active-low reset; start loads word and raises valid;
//        valid/data/ready form the beat; sent pulses on handshake, timed_out on the giving-up edge
module axis_single_word_sender #(
  parameter int DWIDTH = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              ps_clk,
  input  logic              ps_resetn,
  input  logic              start,
  input  logic [DWIDTH-1:0] word,
  input  logic              ready,
  output logic              valid,
  output logic [DWIDTH-1:0] data,
  output logic              sent,
  output logic              timed_out
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count;
  assign sent = valid && ready;
  // the edge that would bring the stall count to TIMEOUT_CYCLES is the one that gives up
  assign timed_out = valid && !ready && count == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge ps_clk or negedge ps_resetn) begin
    if (!ps_resetn) begin
      valid <= 1'b0;
      data <= '0;
      count <= '0;
    end else if (start) begin
      valid <= 1'b1;
      data <= word;
      count <= '0;
    end else if (sent || timed_out) begin
      valid <= 1'b0;
    end else if (valid) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/sample_discriminator_config_sequencer.sv
// sample_discriminator_config_sequencer: shadows discriminator settings and pushes dirty groups on commit
// ports: ps_clk/ps_resetn clock and async active-low reset; cfg_wr_* field write stream (field 7 = commit);
//        ps_thresholds/ps_delays/ps_trigger_select/ps_bypass single-beat stream masters (valid/ready/data/last);
//        busy/done/error/error_group sequence status
module sample_discriminator_config_sequencer
  import sample_discriminator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    ps_clk,
  input  logic                    ps_resetn,
  input  logic                    cfg_wr_valid,
  output logic                    cfg_wr_ready,
  input  logic [2:0]              cfg_wr_field,
  input  logic [CHANNEL_BITS-1:0] cfg_wr_channel,
  input  logic [SAMPLE_WIDTH-1:0] cfg_wr_data,
  output logic                    ps_thresholds_valid,
  input  logic                    ps_thresholds_ready,
  output logic [THR_WIDTH-1:0]    ps_thresholds_data,
  output logic                    ps_thresholds_last,
  output logic                    ps_delays_valid,
  input  logic                    ps_delays_ready,
  output logic [DLY_WIDTH-1:0]    ps_delays_data,
  output logic                    ps_delays_last,
  output logic                    ps_trigger_select_valid,
  input  logic                    ps_trigger_select_ready,
  output logic [SRC_WIDTH-1:0]    ps_trigger_select_data,
  output logic                    ps_trigger_select_last,
  output logic                    ps_bypass_valid,
  input  logic                    ps_bypass_ready,
  output logic [BYP_WIDTH-1:0]    ps_bypass_data,
  output logic                    ps_bypass_last,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              error_group
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, SEND = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [3:0] dirty;
  group_t sel, first;
  field_t field;
  sample_array_t low_thr, high_thr;
  timer_array_t start_dly, stop_dly, digital_dly;
  source_array_t trig_src;
  logic [CHANNELS-1:0] bypass;
  logic wr, in_range, wr_field, wr_commit, start, valid, ready, sent, timed_out;
  logic [THR_WIDTH-1:0] send_word, word;
  assign field = field_t'(cfg_wr_field);
  assign cfg_wr_ready = state == IDLE;
  assign busy = state == SCAN || state == SEND;
  assign done = state == DONE;
  assign wr = cfg_wr_valid && cfg_wr_ready;
  assign in_range = int'(cfg_wr_channel) < CHANNELS;
  assign wr_commit = wr && field == COMMIT;
  assign wr_field = wr && field != COMMIT && in_range;
  assign first = dirty[0] ? GROUP_THR : dirty[1] ? GROUP_DLY : dirty[2] ? GROUP_SRC : GROUP_BYP;
  assign start = state == SCAN && |dirty;
  assign send_word = first == GROUP_THR ? pack_thresholds(low_thr, high_thr) :
                     first == GROUP_DLY ? THR_WIDTH'(pack_delays(start_dly, stop_dly, digital_dly)) :
                     first == GROUP_SRC ? THR_WIDTH'(trig_src) : THR_WIDTH'(bypass);
  assign ready = sel == GROUP_THR ? ps_thresholds_ready :
                 sel == GROUP_DLY ? ps_delays_ready :
                 sel == GROUP_SRC ? ps_trigger_select_ready : ps_bypass_ready;
  assign ps_thresholds_valid = valid && sel == GROUP_THR;
  assign ps_delays_valid = valid && sel == GROUP_DLY;
  assign ps_trigger_select_valid = valid && sel == GROUP_SRC;
  assign ps_bypass_valid = valid && sel == GROUP_BYP;
  assign ps_thresholds_last = ps_thresholds_valid;
  assign ps_delays_last = ps_delays_valid;
  assign ps_trigger_select_last = ps_trigger_select_valid;
  assign ps_bypass_last = ps_bypass_valid;
  assign ps_thresholds_data = word;
  assign ps_delays_data = word[DLY_WIDTH-1:0];
  assign ps_trigger_select_data = word[SRC_WIDTH-1:0];
  assign ps_bypass_data = word[BYP_WIDTH-1:0];
  axis_single_word_sender #(.DWIDTH(THR_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_sender (
    .ps_clk(ps_clk),
    .ps_resetn(ps_resetn),
    .start(start),
    .word(send_word),
    .ready(ready),
    .valid(valid),
    .data(word),
    .sent(sent),
    .timed_out(timed_out)
  );
  always_ff @(posedge ps_clk or negedge ps_resetn) begin
    if (!ps_resetn) begin
      low_thr <= '0;
      high_thr <= '0;
      start_dly <= '0;
      stop_dly <= '0;
      digital_dly <= '0;
      bypass <= '1;
      for (int i = 0; i < CHANNELS; i++) trig_src[i] <= SOURCE_BITS'(i);
    end else if (wr_field) begin
      case (field)
        LOW_THR:     low_thr[cfg_wr_channel] <= cfg_wr_data;
        HIGH_THR:    high_thr[cfg_wr_channel] <= cfg_wr_data;
        START_DLY:   start_dly[cfg_wr_channel] <= cfg_wr_data[TIMER_BITS-1:0];
        STOP_DLY:    stop_dly[cfg_wr_channel] <= cfg_wr_data[TIMER_BITS-1:0];
        DIGITAL_DLY: digital_dly[cfg_wr_channel] <= cfg_wr_data[TIMER_BITS-1:0];
        TRIG_SRC:    trig_src[cfg_wr_channel] <= cfg_wr_data[SOURCE_BITS-1:0];
        BYPASS:      bypass[cfg_wr_channel] <= cfg_wr_data[0];
        default:     ;
      endcase
    end
  end
  // writes only land in IDLE and handshakes only in SEND, so the three updates never collide
  always_ff @(posedge ps_clk or negedge ps_resetn) begin
    if (!ps_resetn) dirty <= '0;
    else if (wr_commit && cfg_wr_data[0]) dirty <= '1;
    else if (wr_field) dirty[field_group(field)] <= 1'b1;
    else if (sent) dirty[sel] <= 1'b0;
  end
  always_ff @(posedge ps_clk or negedge ps_resetn) begin
    if (!ps_resetn) begin
      state <= IDLE;
      sel <= GROUP_THR;
      error <= 1'b0;
      error_group <= 2'd0;
    end else begin
      case (state)
        IDLE: if (wr_commit) begin
          state <= SCAN;
          error <= 1'b0;
        end
        SCAN: begin
          state <= |dirty ? SEND : DONE;
          sel <= first;
        end
        SEND: if (sent) state <= SCAN;
        else if (timed_out) begin
          state <= IDLE;
          error <= 1'b1;
          error_group <= sel;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_discriminator_config_sequencer.sv
// tb_sample_discriminator_config_sequencer: directed and randomized checks against a behavioural model
module tb_sample_discriminator_config_sequencer;
  import sample_discriminator_pkg::*;
  logic ps_clk = 1'b0, ps_resetn = 1'b0;
  logic cfg_wr_valid = 1'b0, cfg_wr_ready;
  logic [2:0] cfg_wr_field = '0;
  logic [CHANNEL_BITS-1:0] cfg_wr_channel = '0;
  logic [SAMPLE_WIDTH-1:0] cfg_wr_data = '0;
  logic thr_valid, thr_ready = 1'b1, thr_last;
  logic [THR_WIDTH-1:0] thr_data;
  logic dly_valid, dly_ready = 1'b1, dly_last;
  logic [DLY_WIDTH-1:0] dly_data;
  logic src_valid, src_ready = 1'b1, src_last;
  logic [SRC_WIDTH-1:0] src_data;
  logic byp_valid, byp_ready = 1'b1, byp_last;
  logic [BYP_WIDTH-1:0] byp_data;
  logic busy, done, error;
  logic [1:0] error_group;
  logic [3:0] vmask, lmask;
  always #5 ps_clk = ~ps_clk;
  sample_discriminator_config_sequencer dut (
    .ps_clk(ps_clk), .ps_resetn(ps_resetn),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready), .cfg_wr_field(cfg_wr_field),
    .cfg_wr_channel(cfg_wr_channel), .cfg_wr_data(cfg_wr_data),
    .ps_thresholds_valid(thr_valid), .ps_thresholds_ready(thr_ready),
    .ps_thresholds_data(thr_data), .ps_thresholds_last(thr_last),
    .ps_delays_valid(dly_valid), .ps_delays_ready(dly_ready),
    .ps_delays_data(dly_data), .ps_delays_last(dly_last),
    .ps_trigger_select_valid(src_valid), .ps_trigger_select_ready(src_ready),
    .ps_trigger_select_data(src_data), .ps_trigger_select_last(src_last),
    .ps_bypass_valid(byp_valid), .ps_bypass_ready(byp_ready),
    .ps_bypass_data(byp_data), .ps_bypass_last(byp_last),
    .busy(busy), .done(done), .error(error), .error_group(error_group)
  );
  assign vmask = {byp_valid, src_valid, dly_valid, thr_valid};
  assign lmask = {byp_last, src_last, dly_last, thr_last};
  typedef struct {int g; logic [95:0] d; int cyc;} beat_t;
  beat_t beats[$];
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, dly_valid_cnt = 0;
  sample_array_t m_low, m_high;
  timer_array_t m_start, m_stop, m_dig;
  int m_src[CHANNELS];
  bit m_byp[CHANNELS];
  bit m_dirty[4];
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(posedge ps_clk) cyc <= cyc + 1;
  always @(negedge ps_clk) begin
    if (|vmask) begin
      chk("onehot_valid", 96'($countones(vmask)), 96'(1));
      chk("last_with_valid", 96'(lmask), 96'(vmask));
    end
    if (done) done_cnt++;
    if (dly_valid) dly_valid_cnt++;
    if (thr_valid && thr_ready) beats.push_back('{0, 96'(thr_data), cyc});
    if (dly_valid && dly_ready) beats.push_back('{1, 96'(dly_data), cyc});
    if (src_valid && src_ready) beats.push_back('{2, 96'(src_data), cyc});
    if (byp_valid && byp_ready) beats.push_back('{3, 96'(byp_data), cyc});
  end
  task automatic model_reset();
    m_low = '0; m_high = '0; m_start = '0; m_stop = '0; m_dig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      m_src[i] = i;
      m_byp[i] = 1'b1;
    end
    for (int g = 0; g < 4; g++) m_dirty[g] = 1'b0;
  endtask
  task automatic model_write(input int f, input int ch, input logic [15:0] d);
    if (ch >= CHANNELS) return;
    case (f)
      0: m_low[ch] = d;
      1: m_high[ch] = d;
      2: m_start[ch] = d[TIMER_BITS-1:0];
      3: m_stop[ch] = d[TIMER_BITS-1:0];
      4: m_dig[ch] = d[TIMER_BITS-1:0];
      5: m_src[ch] = int'(d) % (1 << SOURCE_BITS);
      default: m_byp[ch] = d[0];
    endcase
    m_dirty[f < 2 ? 0 : f < 5 ? 1 : f == 5 ? 2 : 3] = 1'b1;
  endtask
  function automatic logic [95:0] model_word(input int g);
    logic [95:0] w;
    w = '0;
    case (g)
      0: w = 96'(pack_thresholds(m_low, m_high));
      1: w = 96'(pack_delays(m_start, m_stop, m_dig));
      2: for (int i = 0; i < CHANNELS; i++) w[i*SOURCE_BITS +: SOURCE_BITS] = SOURCE_BITS'(m_src[i]);
      default: for (int i = 0; i < CHANNELS; i++) w[i] = m_byp[i];
    endcase
    return w;
  endfunction
  task automatic wr(input int f, input int ch, input logic [15:0] d);
    @(negedge ps_clk);
    cfg_wr_valid = 1'b1;
    cfg_wr_field = 3'(f);
    cfg_wr_channel = CHANNEL_BITS'(ch);
    cfg_wr_data = d;
    chk("wr_ready", 96'(cfg_wr_ready), 96'(1));
    @(posedge ps_clk);
    #1 cfg_wr_valid = 1'b0;
    if (f != 7) begin
      model_write(f, ch, d);
      chk("wr_ready_after_field", 96'(cfg_wr_ready), 96'(1));
    end
  endtask
  // blocked: group whose ready is held low for the whole commit (-1 for none)
  task automatic run_commit(input bit force_all, input int blocked);
    beat_t exp[$];
    bit to = 1'b0;
    beats.delete();
    done_cnt = 0;
    for (int g = 0; g < 4; g++) if (force_all) m_dirty[g] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      if (m_dirty[g] && !to) begin
        if (g == blocked) to = 1'b1;
        else begin
          exp.push_back('{g, model_word(g), 0});
          m_dirty[g] = 1'b0;
        end
      end
    end
    wr(7, 0, 16'(force_all));
    chk("busy_after_commit", 96'(busy), 96'(1));
    chk("error_cleared", 96'(error), 96'(0));
    for (int w = 0; w < 400; w++) begin
      @(negedge ps_clk);
      if (cfg_wr_ready) break;
    end
    chk("sequence_ends", 96'(cfg_wr_ready), 96'(1));
    chk("busy_end", 96'(busy), 96'(0));
    chk("beat_count", 96'(beats.size()), 96'(exp.size()));
    for (int i = 0; i < exp.size() && i < beats.size(); i++) begin
      chk("beat_group", 96'(beats[i].g), 96'(exp[i].g));
      chk("beat_data", beats[i].d, exp[i].d);
    end
    chk("done_pulses", 96'(done_cnt), 96'(!to));
    chk("error_flag", 96'(error), 96'(to));
    if (to) chk("error_group", 96'(error_group), 96'(blocked));
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge ps_clk);
    chk("rst_valids", 96'(vmask), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_error", 96'(error), 96'(0));
    chk("rst_error_group", 96'(error_group), 96'(0));
    chk("rst_wr_ready", 96'(cfg_wr_ready), 96'(1));
    ps_resetn = 1'b1;
    // single threshold group
    wr(0, 0, 16'h0100);
    wr(1, 0, 16'h0400);
    run_commit(1'b0, -1);
    if (beats.size() > 0) begin
      chk("thr_word_ch0", 96'(beats[0].d[31:0]), 96'(32'h04000100));
      chk("thr_word_rest", 96'(beats[0].d[95:32]), 96'(0));
    end
    // forced commit: all four groups, one idle cycle between beats
    run_commit(1'b1, -1);
    for (int i = 1; i < beats.size(); i++) chk("beat_gap", 96'(beats[i].cyc - beats[i-1].cyc), 96'(2));
    // delay group times out; delay and bypass stay dirty
    wr(2, 1, 16'd5);
    wr(6, 2, 16'd0);
    dly_ready = 1'b0;
    dly_valid_cnt = 0;
    run_commit(1'b0, 1);
    chk("timeout_valid_cycles", 96'(dly_valid_cnt), 96'(16));
    dly_ready = 1'b1;
    run_commit(1'b0, -1);
    // nothing dirty: done two cycles after acceptance, no beats
    beats.delete();
    done_cnt = 0;
    wr(7, 0, 16'd0);
    @(negedge ps_clk);
    chk("empty_scan_ready", 96'(cfg_wr_ready), 96'(0));
    chk("empty_scan_done", 96'(done), 96'(0));
    @(negedge ps_clk);
    chk("empty_done", 96'(done), 96'(1));
    chk("empty_done_busy", 96'(busy), 96'(0));
    chk("empty_done_ready", 96'(cfg_wr_ready), 96'(0));
    @(negedge ps_clk);
    chk("empty_idle_ready", 96'(cfg_wr_ready), 96'(1));
    chk("empty_idle_done", 96'(done), 96'(0));
    chk("empty_beats", 96'(beats.size()), 96'(0));
    chk("empty_done_count", 96'(done_cnt), 96'(1));
    // asynchronous reset in the middle of a send
    wr(0, 2, 16'h1234);
    thr_ready = 1'b0;
    wr(7, 0, 16'd0);
    for (int w = 0; w < 50; w++) begin
      @(negedge ps_clk);
      if (thr_valid) break;
    end
    chk("send_started", 96'(thr_valid), 96'(1));
    #2 ps_resetn = 1'b0;
    #1;
    chk("async_rst_valid", 96'(thr_valid), 96'(0));
    chk("async_rst_busy", 96'(busy), 96'(0));
    @(negedge ps_clk);
    ps_resetn = 1'b1;
    thr_ready = 1'b1;
    model_reset();
    run_commit(1'b0, -1);
    run_commit(1'b1, -1);
    // out-of-range channel writes are swallowed
    for (int f = 0; f < 7; f++) wr(f, CHANNELS, 16'($urandom));
    run_commit(1'b0, -1);
    run_commit(1'b1, -1);
    // randomized field writes and commits
    for (int it = 0; it < 15; it++) begin
      int n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) wr(int'($urandom_range(0, 6)), int'($urandom_range(0, CHANNELS)), 16'($urandom));
      run_commit(1'($urandom_range(0, 1)), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
